// File: rtl/seq_array_divider_approx_if.sv
// Operand/result handshake bundle for seq_array_divider_approx.
// exact_mode is present only when DIVIDER_RUNTIME_EXACT_EN is defined.
interface seq_array_divider_approx_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] n;
  logic [N-1:0]   d;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           ovf;
  logic           busy;
`ifdef DIVIDER_RUNTIME_EXACT_EN
  logic           exact_mode;

  modport master (
    output in_valid, n, d, out_ready, exact_mode,
    input  in_ready, out_valid, q, r, ovf, busy
  );
  modport slave (
    input  in_valid, n, d, out_ready, exact_mode,
    output in_ready, out_valid, q, r, ovf, busy
  );
`else
  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, r, ovf, busy
  );
  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, r, ovf, busy
  );
`endif
endinterface

// File: rtl/seq_array_divider_approx.sv
// Row-per-cycle restoring array divider with approximate low rows/columns.
// DIVIDER_RUNTIME_EXACT_EN adds a per-operation exact_mode override.
module seq_array_divider_approx #(
  parameter int N           = 8,
  parameter int APPROX_ROWS = 6,
  parameter int APPROX_COLS = 8
) (
  input logic                        clk,
  input logic                        rst_n,
  seq_array_divider_approx_if.slave  bus
);
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            top;
  logic [N-1:0]    rem;
  logic [N-1:0]    dvs;
  logic [N-2:0]    dvd;
  logic [N-1:0]    qreg;
  logic [KW-1:0]   k;
  logic            ovf_p;
  logic [N-1:0]    q_o;
  logic [N-1:0]    r_o;
  logic            ovf_o;
  logic            mode;
  logic            accept;
  logic            last;
  logic            apx_row;
  logic            bout;
  logic            qk;
  logic [N-1:0]    diff;
  logic [N-1:0]    nw;
  logic [N-1:0]    q_nx;

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (k == '0);

  // One subtractor row; approximate cells just toggle the borrow
  always_comb begin
    logic b;
    b       = 1'b0;
    diff    = '0;
    apx_row = !mode && (int'(k) < APPROX_ROWS);
    for (int j = 0; j < N; j++) begin
      diff[j] = rem[j] ^ dvs[j] ^ b;
      if (apx_row && j < APPROX_COLS)
        b = ~b;
      else
        b = (~rem[j] & dvs[j]) |
            (~(rem[j] ^ dvs[j]) & b);
    end
    bout    = b;
    qk      = top | ~bout;
    nw      = qk ? diff : rem;
    q_nx    = qreg;
    q_nx[k] = qk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top   <= 1'b0;
      rem   <= '0;
      dvs   <= '0;
      dvd   <= '0;
      qreg  <= '0;
      k     <= '0;
      ovf_p <= 1'b0;
      q_o   <= '0;
      r_o   <= '0;
      ovf_o <= 1'b0;
    end else if (accept) begin
      top   <= bus.n[2*N-1];
      rem   <= bus.n[2*N-2:N-1];
      dvs   <= bus.d;
      dvd   <= bus.n[N-2:0];
      qreg  <= '0;
      k     <= KW'(N-1);
      ovf_p <= bus.n[2*N-1:N] >= bus.d;
    end else if (state == RUN) begin
      qreg <= q_nx;
      if (last) begin
        q_o   <= q_nx;
        r_o   <= nw;
        ovf_o <= ovf_p;
      end else begin
        top <= nw[N-1];
        rem <= {nw[N-2:0], dvd[k-KW'(1)]};
        k   <= k - KW'(1);
      end
    end
  end

`ifdef DIVIDER_RUNTIME_EXACT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mode <= 1'b0;
    else if (accept)
      mode <= bus.exact_mode;
  end
`else
  assign mode = 1'b0;
`endif

  // in_ready stays low while reset is held
  assign bus.in_ready  = rst_n & (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.q         = q_o;
  assign bus.r         = r_o;
  assign bus.ovf       = ovf_o;
endmodule

// File: tb/tb_seq_array_divider_approx.sv
// Directed bench for seq_array_divider_approx: exact (0,8) and
// default-approximate (6,8) instances side by side.
module tb_seq_array_divider_approx;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_array_divider_approx_if #(.N(8)) ix ();
  seq_array_divider_approx_if #(.N(8)) ia ();

  seq_array_divider_approx #(
    .N(8), .APPROX_ROWS(0), .APPROX_COLS(8)
  ) dut_x (
    .clk(clk), .rst_n(rst_n), .bus(ix.slave)
  );

  seq_array_divider_approx #(
    .N(8), .APPROX_ROWS(6), .APPROX_COLS(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_x(input logic [15:0] nn,
                      input logic [7:0] dd,
                      output int lat);
    ix.n = nn;
    ix.d = dd;
    ix.in_valid = 1'b1;
    tick();
    ix.in_valid = 1'b0;
    lat = 0;
    while (ix.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic op_a(input logic [15:0] nn,
                      input logic [7:0] dd,
                      output int lat);
    ia.n = nn;
    ia.d = dd;
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    lat = 0;
    while (ia.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume_x();
    ix.out_ready = 1'b1;
    tick();
    ix.out_ready = 1'b0;
  endtask

  task automatic consume_a();
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
  endtask

  // Cell-level model of the (6,8) array: borrow from signed column sum
  function automatic void model_div(input logic [15:0] nn,
                                    input logic [7:0] dd,
                                    output logic [7:0] mq,
                                    output logic [7:0] mr);
    logic [8:0] p;
    logic [7:0] df;
    logic [7:0] nw;
    logic       b;
    logic       qb;
    int         s;
    p  = nn[15:7];
    mq = '0;
    mr = '0;
    df = '0;
    for (int k = 7; k >= 0; k--) begin
      b = 1'b0;
      for (int j = 0; j < 8; j++) begin
        s = int'(p[j]) - int'(dd[j]) - int'(b);
        df[j] = s[0];
        if (k < 6) b = ~b;
        else b = (s < 0);
      end
      qb = p[8] | ~b;
      nw = qb ? df : p[7:0];
      mq[k] = qb;
      if (k > 0) p = {nw, nn[k-1]};
      else mr = nw;
    end
  endfunction

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    ix.in_valid = 1'b1;
    ix.n = 16'd200;
    ix.d = 8'd7;
    tick();
    tick();
    checks++;
    if (ix.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", ix.out_valid);
    end
    checks++;
    if (ix.q !== 8'd0 || ix.r !== 8'd0) begin
      errors++;
      $display("FAIL reset_qr got q=%0d r=%0d want 0 0", ix.q, ix.r);
    end
    checks++;
    if (ix.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", ix.ovf);
    end
    checks++;
    if (ix.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_low got %b want 0", ix.in_ready);
    end
    checks++;
    if (ix.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", ix.busy);
    end
    rst_n = 1'b1;
    ix.in_valid = 1'b0;
    #1;
    checks++;
    if (ix.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_after got %b want 1", ix.in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    int lat;
    op_x(16'd200, 8'd7, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency got %0d want 8", lat);
    end
    checks++;
    if (ix.q !== 8'd28 || ix.r !== 8'd4) begin
      errors++;
      $display("FAIL basic_qr got q=%0d r=%0d want 28 4", ix.q, ix.r);
    end
    checks++;
    if (ix.ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf got %b want 0", ix.ovf);
    end
    consume_x();
    checks++;
    if (ix.out_valid !== 1'b0 || ix.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_consume got ov=%b ir=%b want 0 1",
               ix.out_valid, ix.in_ready);
    end
  endtask

  task automatic test_overflow();
    int lat;
    op_x(16'h0800, 8'd5, lat);
    checks++;
    if (ix.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_big got %b want 1", ix.ovf);
    end
    consume_x();
    op_x(16'd100, 8'd0, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL div0_latency got %0d want 8", lat);
    end
    checks++;
    if (ix.ovf !== 1'b1) begin
      errors++;
      $display("FAIL div0_ovf got %b want 1", ix.ovf);
    end
    consume_x();
    checks++;
    if (ix.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL div0_in_ready got %b want 1", ix.in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    op_x(16'd1000, 8'd33, lat);
    ix.n = 16'd300;
    ix.d = 8'd7;
    ix.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ix.out_valid !== 1'b1 || ix.q !== 8'd30 ||
          ix.r !== 8'd10 || ix.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b q=%0d r=%0d ir=%b want 1 30 10 0",
                 i, ix.out_valid, ix.q, ix.r, ix.in_ready);
      end
      tick();
    end
    ix.n = 16'd500;
    ix.d = 8'd9;
    ix.out_ready = 1'b1;
    tick();
    ix.out_ready = 1'b0;
    checks++;
    if (ix.out_valid !== 1'b0 || ix.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ov=%b ir=%b want 0 1",
               ix.out_valid, ix.in_ready);
    end
    tick();
    ix.in_valid = 1'b0;
    checks++;
    if (ix.busy !== 1'b1 || ix.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got busy=%b ir=%b want 1 0",
               ix.busy, ix.in_ready);
    end
    lat = 0;
    while (ix.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 8 || ix.q !== 8'd55 || ix.r !== 8'd5) begin
      errors++;
      $display("FAIL bp_second got lat=%0d q=%0d r=%0d want 8 55 5",
               lat, ix.q, ix.r);
    end
    consume_x();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    ix.n = 16'd200;
    ix.d = 8'd7;
    ix.in_valid = 1'b1;
    tick();
    ix.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ix.out_valid !== 1'b0 || ix.busy !== 1'b0 ||
        ix.q !== 8'd0 || ix.r !== 8'd0 || ix.ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrun_clear got ov=%b busy=%b q=%0d r=%0d ovf=%b want 0",
               ix.out_valid, ix.busy, ix.q, ix.r, ix.ovf);
    end
    tick();
    rst_n = 1'b1;
    tick();
    op_x(16'd255, 8'd16, lat);
    checks++;
    if (lat !== 8 || ix.q !== 8'd15 || ix.r !== 8'd15) begin
      errors++;
      $display("FAIL midrun_fresh got lat=%0d q=%0d r=%0d want 8 15 15",
               lat, ix.q, ix.r);
    end
    consume_x();
  endtask

  task automatic test_approx();
    int         lat;
    int         qe;
    logic [15:0] nn;
    logic [7:0]  dd;
    logic [7:0]  mq;
    logic [7:0]  mr;
    logic [7:0]  qx;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin
        nn = 16'd200;
        dd = 8'd7;
      end else if (i == 1) begin
        nn = 16'h7FFF;
        dd = 8'd128;
      end else begin
        dd = 8'($urandom_range(1, 255));
        nn[15:8] = 8'($urandom_range(0, int'(dd) - 1));
        nn[7:0] = 8'($urandom);
      end
      model_div(nn, dd, mq, mr);
      qe = int'(nn) / int'(dd);
      qx = 8'(qe);
      op_a(nn, dd, lat);
      checks++;
      if (lat !== 8 || ia.q !== mq || ia.r !== mr) begin
        errors++;
        $display("FAIL approx n=%0d d=%0d got lat=%0d q=%0d r=%0d want 8 %0d %0d",
                 nn, dd, lat, ia.q, ia.r, mq, mr);
      end
      checks++;
      if (ia.q[7:6] !== qx[7:6]) begin
        errors++;
        $display("FAIL approx_hi n=%0d d=%0d got %b want %b",
                 nn, dd, ia.q[7:6], qx[7:6]);
      end
      consume_a();
    end
  endtask

`ifdef DIVIDER_RUNTIME_EXACT_EN
  task automatic test_exact_mode();
    int lat;
    ia.exact_mode = 1'b1;
    op_a(16'd200, 8'd7, lat);
    ia.exact_mode = 1'b0;
    checks++;
    if (lat !== 8 || ia.q !== 8'd28 || ia.r !== 8'd4) begin
      errors++;
      $display("FAIL exact_mode got lat=%0d q=%0d r=%0d want 8 28 4",
               lat, ia.q, ia.r);
    end
    consume_a();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ix.in_valid = 1'b0;
    ix.out_ready = 1'b0;
    ix.n = '0;
    ix.d = '0;
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b0;
    ia.n = '0;
    ia.d = '0;
`ifdef DIVIDER_RUNTIME_EXACT_EN
    ix.exact_mode = 1'b0;
    ia.exact_mode = 1'b0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_approx();
`ifdef DIVIDER_RUNTIME_EXACT_EN
    test_exact_mode();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
